// File: rtl/uart_rx_jogada.sv
// uart_rx_jogada: 8N1 receiver that pairs bytes (high first) into a 16-bit status word; ports clock/reset/s_in in, estado/macro/micro/resultado_macro/resultado_jogo fields plus word_valid/frame_error/timeout_error pulses and busy out
module uart_rx_jogada #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_in,
  output logic [3:0] estado,
  output logic [3:0] macro,
  output logic [3:0] micro,
  output logic [1:0] resultado_macro,
  output logic [1:0] resultado_jogo,
  output logic       word_valid,
  output logic       frame_error,
  output logic       timeout_error,
  output logic       busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TMO);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state, nxt;
  logic rx_meta, rx, idx, tick, byte_ok, bad_stop, tmo_hit;
  logic [CW-1:0] clk_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, high;
  logic [TW-1:0] tmo_cnt;
  always_comb begin
    tick = clk_cnt == (state == START ? CW'(HALF - 1) : CW'(CLKS_PER_BIT - 1));
    byte_ok = state == STOP && tick && rx;
    bad_stop = state == STOP && tick && !rx;
    tmo_hit = idx && state == IDLE && tmo_cnt == TW'(TMO - 1);
    nxt = state;
    case (state)
      IDLE:      nxt = rx ? IDLE : START;
      START:     nxt = !tick ? START : rx ? IDLE : DATA;
      DATA:      nxt = tick && bit_cnt == 3'd7 ? STOP : DATA;
      STOP:      nxt = !tick ? STOP : rx ? IDLE : WAIT_HIGH;
      WAIT_HIGH: nxt = rx ? IDLE : WAIT_HIGH;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  assign busy = state != IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx <= 1'b1;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      high <= '0;
      idx <= 1'b0;
      tmo_cnt <= '0;
      {estado, macro, micro, resultado_macro, resultado_jogo} <= '0;
      word_valid <= 1'b0;
      frame_error <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      rx_meta <= s_in;
      rx <= rx_meta;
      word_valid <= byte_ok && idx;
      frame_error <= bad_stop;
      timeout_error <= tmo_hit;
      clk_cnt <= (state == IDLE || state == WAIT_HIGH || tick) ? '0 : clk_cnt + CW'(1);
      bit_cnt <= state != DATA ? '0 : (tick && bit_cnt != 3'd7) ? bit_cnt + 3'd1 : bit_cnt;
      if (state == DATA && tick) shift <= {rx, shift[7:1]};
      tmo_cnt <= (!idx || state != IDLE || tmo_hit) ? '0 : tmo_cnt + TW'(1);
      if (byte_ok && !idx) begin
        high <= shift;
        idx <= 1'b1;
      end
      if (byte_ok && idx) begin
        {estado, macro, micro, resultado_macro, resultado_jogo} <= {high, shift};
        idx <= 1'b0;
      end
      if (bad_stop) idx <= 1'b0;
      if (tmo_hit) begin
        idx <= 1'b0;
        high <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_jogada.sv
// tb_uart_rx_jogada: directed and random frames against a word-level reference of the status receiver
module tb_uart_rx_jogada;
  localparam int CPB = 16;
  localparam int TB = 4;
  logic clock = 1'b0, reset = 1'b1, s_in = 1'b1;
  logic [3:0] estado, macro, micro;
  logic [1:0] resultado_macro, resultado_jogo;
  logic word_valid, frame_error, timeout_error, busy;
  int cyc = 0, wv_cnt = 0, fe_cnt = 0, te_cnt = 0, tmo_at = -1;
  int checks = 0, errors = 0;
  logic [15:0] last_word = '0;
  uart_rx_jogada #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TB)) dut (
    .clock(clock), .reset(reset), .s_in(s_in),
    .estado(estado), .macro(macro), .micro(micro),
    .resultado_macro(resultado_macro), .resultado_jogo(resultado_jogo),
    .word_valid(word_valid), .frame_error(frame_error),
    .timeout_error(timeout_error), .busy(busy)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (word_valid) begin
      wv_cnt++;
      last_word = {estado, macro, micro, resultado_macro, resultado_jogo};
    end
    if (frame_error) fe_cnt++;
    if (timeout_error) begin
      te_cnt++;
      tmo_at = cyc;
    end
  end
  function automatic logic [15:0] fields();
    return {estado, macro, micro, resultado_macro, resultado_jogo};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] b, input logic stop, input int n);
    s_in = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < n; i++) begin
      s_in = b[i];
      repeat (CPB) @(negedge clock);
    end
    if (n == 8) begin
      s_in = stop;
      repeat (CPB) @(negedge clock);
      s_in = 1'b1;
    end
  endtask
  task automatic send_word(input logic [15:0] w, input int gap);
    send_bits(w[15:8], 1'b1, 8);
    repeat (gap) @(negedge clock);
    send_bits(w[7:0], 1'b1, 8);
  endtask
  initial begin
    int wv0, fe0, te0, t0;
    logic [15:0] w;
    repeat (3) @(negedge clock);
    chk("reset_fields", 32'(fields()), 32'h0);
    chk("reset_pulses", 32'({word_valid, frame_error, timeout_error, busy}), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    wv0 = wv_cnt; fe0 = fe_cnt; te0 = te_cnt;
    send_word(16'h5379, 0);
    repeat (8) @(negedge clock);
    chk("basic_wv", 32'(wv_cnt - wv0), 32'd1);
    chk("basic_estado", 32'(estado), 32'h5);
    chk("basic_macro", 32'(macro), 32'h3);
    chk("basic_micro", 32'(micro), 32'h7);
    chk("basic_rmacro", 32'(resultado_macro), 32'h2);
    chk("basic_rjogo", 32'(resultado_jogo), 32'h1);
    chk("basic_noerr", 32'((fe_cnt - fe0) + (te_cnt - te0)), 32'd0);
    wv0 = wv_cnt;
    send_word(16'hFFFF, 0);
    chk("b2b_ones", 32'(last_word), 32'hFFFF);
    send_word(16'h0000, 0);
    repeat (8) @(negedge clock);
    chk("b2b_zeros", 32'(fields()), 32'h0000);
    chk("b2b_wv", 32'(wv_cnt - wv0), 32'd2);
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_bits(8'h53, 1'b0, 8);
    repeat (CPB) @(negedge clock);
    chk("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_fields_hold", 32'(fields()), 32'h0000);
    send_word(16'hA10C, 0);
    repeat (8) @(negedge clock);
    chk("fe_wv", 32'(wv_cnt - wv0), 32'd1);
    chk("fe_word", 32'(fields()), 32'hA10C);
    chk("fe_rmacro", 32'(resultado_macro), 32'h3);
    wv0 = wv_cnt; te0 = te_cnt; fe0 = fe_cnt;
    t0 = cyc;
    send_bits(8'h53, 1'b1, 8);
    repeat (5 * CPB) @(negedge clock);
    chk("tmo_pulse", 32'(te_cnt - te0), 32'd1);
    chk("tmo_time", 32'(tmo_at - t0 >= 217 && tmo_at - t0 <= 221), 32'd1);
    chk("tmo_fields_hold", 32'(fields()), 32'hA10C);
    chk("tmo_no_wv", 32'(wv_cnt - wv0), 32'd0);
    send_word(16'h1234, 0);
    repeat (8) @(negedge clock);
    chk("tmo_next_word", 32'(fields()), 32'h1234);
    chk("tmo_next_wv", 32'(wv_cnt - wv0), 32'd1);
    wv0 = wv_cnt; te0 = te_cnt; fe0 = fe_cnt;
    s_in = 1'b0;
    repeat (4) @(negedge clock);
    s_in = 1'b1;
    repeat (2) @(negedge clock);
    chk("glitch_busy_early", 32'(busy), 32'd1);
    repeat (8) @(negedge clock);
    chk("glitch_busy_late", 32'(busy), 32'd0);
    repeat (20) @(negedge clock);
    chk("glitch_quiet", 32'((wv_cnt - wv0) + (fe_cnt - fe0) + (te_cnt - te0)), 32'd0);
    send_word(16'h5379, 0);
    repeat (8) @(negedge clock);
    chk("glitch_word", 32'(fields()), 32'h5379);
    chk("glitch_wv", 32'(wv_cnt - wv0), 32'd1);
    send_word(16'h1234, 0);
    send_bits(8'h53, 1'b1, 8);
    send_bits(8'h79, 1'b1, 3);
    s_in = 1'b1;
    repeat (8) @(negedge clock);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_fields", 32'(fields()), 32'h0);
    chk("rst_async_flags", 32'({word_valid, frame_error, timeout_error, busy}), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    wv0 = wv_cnt;
    send_word(16'h5379, 0);
    repeat (8) @(negedge clock);
    chk("rst_resend_word", 32'(fields()), 32'h5379);
    chk("rst_resend_wv", 32'(wv_cnt - wv0), 32'd1);
    fe0 = fe_cnt; te0 = te_cnt;
    for (int k = 0; k < 6; k++) begin
      w = 16'($urandom);
      wv0 = wv_cnt;
      send_word(w, int'($urandom_range(0, 40)));
      repeat (int'($urandom_range(4, 30))) @(negedge clock);
      chk("rand_wv", 32'(wv_cnt - wv0), 32'd1);
      chk("rand_estado", 32'(estado), 32'(w >> 12));
      chk("rand_low", 32'({micro, resultado_macro, resultado_jogo}), 32'(w & 16'h00FF));
      chk("rand_macro", 32'(macro), 32'((w >> 8) & 16'hF));
    end
    chk("rand_noerr", 32'((fe_cnt - fe0) + (te_cnt - te0)), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_jogada.md
Name: uart_rx_jogada

Overview:
- Serial receiver for the game-status link; the receiving end of the 16-bit status word the game top transmits on s_out.
- Recovers 8N1 bytes from the serial line and reassembles two bytes into one status word.
- Splits the word into estado, macro, micro, resultado_macro and resultado_jogo fields.
- Sits on the host/monitor board, or in a loopback bench, and drives status displays or a checker.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200 baud).
- TIMEOUT_BITS, 20, maximum idle time in bit periods between the first and second byte of a word.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- s_in  in  1  serial line; idles high.
- estado  out  4  received word bits [15:12].
- macro  out  4  received word bits [11:8].
- micro  out  4  received word bits [7:4].
- resultado_macro  out  2  received word bits [3:2].
- resultado_jogo  out  2  received word bits [1:0].
- word_valid  out  1  one-cycle pulse when a new word is on the field outputs.
- frame_error  out  1  one-cycle pulse on a bad stop bit.
- timeout_error  out  1  one-cycle pulse when the second byte does not arrive in time.
- busy  out  1  high whenever the bit FSM is not in IDLE.

Behaviour:
- Reset: all field outputs are 0; word_valid, frame_error, timeout_error and busy are 0; FSM is IDLE; byte index is 0; the pending high byte is cleared.
- s_in passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value rx.
- Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1). The word is sent as two bytes, high byte [15:8] first, then low byte [7:0].
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx=0, go to START and clear the bit counter.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rx. If rx=0, go to DATA. If rx=1, treat it as a glitch and return to IDLE with no error.
  - DATA: sample rx every CLKS_PER_BIT cycles into shift bit n (n = 0..7). After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx.
    - rx=1: the byte is good; go to IDLE.
    - rx=0: pulse frame_error, discard the byte, reset byte index to 0, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx=1, then go to IDLE. A break or stuck-low line never produces a spurious start.
- Byte assembly:
  - Good byte with index 0: latch it as the high byte, set index to 1, start the timeout counter.
  - Good byte with index 1: in the same cycle, load all field outputs from {high, low}, pulse word_valid, and set index to 0.
  - word_valid rises on the clock edge after the low byte's stop-bit sample. Field outputs hold until the next word_valid.
- Timeout:
  - While index=1 and the FSM is in IDLE, count cycles.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles: pulse timeout_error, set index to 0, discard the high byte.
  - The counter clears on a start-bit detection and whenever index=0.
- A frame_error or timeout_error never changes the field outputs.
- Asynchronous reset mid-frame aborts immediately. After reset release, the first falling edge on rx starts a new frame at index 0.
- Counters are sized with $clog2 of their terminal counts. The bit counter wraps only through the state transitions, never by overflow.

Test Plan (bench uses CLKS_PER_BIT=16, TIMEOUT_BITS=4):
- Basic word: send bytes 0x53 then 0x79 → exactly one word_valid pulse; estado=4'h5, macro=4'h3, micro=4'h7, resultado_macro=2'b10, resultado_jogo=2'b01. No error pulses.
- Back-to-back words: send 0xFF,0xFF then 0x00,0x00 with no idle gap → two word_valid pulses. Fields go to all ones, then all zeros.
- Frame error: send 0x53 with stop bit 0, then good bytes 0xA1,0x0C → one frame_error pulse, then word_valid with estado=4'hA, macro=4'h1, micro=4'h0, resultado_macro=2'b11, resultado_jogo=2'b00.
- Timeout: send 0x53, idle 5 bit times, then send 0x12,0x34 → timeout_error pulses once at 64 cycles after the first stop sample; the next word_valid gives fields from 0x1234.
- Glitch: drive s_in low for 4 cycles only → no busy past the half-bit point, no word_valid, no errors; the following word 0x5379 decodes correctly.
- Reset mid-frame: assert reset during bit 3 of the low byte → all outputs 0 immediately. Resend 0x53,0x79 → exact decode with a single word_valid.
